btn_debounce: RTL and testbench
===============================

# btn_debounce

Debounces and conditions the study board's push buttons, the input-side counterpart of the LED drivers. Each button input is synchronised to `clk` and filtered with a shared millisecond tick derived from the 10 MHz system clock. The block emits a clean level, single-cycle press and release pulses, and a long-press pulse. Application logic such as LED pattern selectors consumes these outputs instead of raw pins.

## Interface
Parameters:
- `NBTN`, 4: number of buttons.
- `CLK_HZ`, 10_000_000: `clk` frequency.
- `TICK_HZ`, 1000: debounce tick rate. `CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `DEB_TICKS`, 20: consecutive stable ticks needed to accept a change (≥ 1).
- `LONG_TICKS`, 1000: held ticks before a long press is reported (> `DEB_TICKS`).
- `REPEAT_TICKS`, 200: auto-repeat period in ticks. Used only with `BTN_AUTOREPEAT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_n`  in  NBTN  raw button pins, active-low (pressed = 0), asynchronous to `clk`.
- `level`  out  NBTN  debounced state, 1 = pressed.
- `press`  out  NBTN  1-cycle pulse on an accepted press (also carries auto-repeat pulses).
- `release`  out  NBTN  1-cycle pulse on an accepted release.
- `long`  out  NBTN  1-cycle pulse when a hold reaches `LONG_TICKS`.
- `tick`  out  1  1-cycle debounce tick, exported for other blocks.

## Operation
- **Prescaler.** Counts 0..`CLK_HZ/TICK_HZ-1` and wraps. `tick` is high for the one cycle in which the count equals the terminal value. Width is `$clog2(CLK_HZ/TICK_HZ)`.
- **Synchroniser.** Each button passes through a 2-flop synchroniser on `~btn_n`, giving `s[i]` with 1 = pressed.
- **Debounce counter** (`$clog2(DEB_TICKS+1)` bits, one per button):
  - Cleared in any cycle where `s[i] == level[i]`.
  - Incremented on `tick` while `s[i] != level[i]`.
  - On the tick where it would reach `DEB_TICKS`, the change is accepted: `level[i]` toggles, the counter clears, and `press[i]` or `release[i]` pulses, all at that clock edge.
  - Any glitch back to the current level before acceptance restarts the count from 0.
- **Per-button FSM:**
  - `UP`: released. On an accepted press → `DOWN`, hold counter cleared.
  - `DOWN`: the hold counter increments on each `tick`. When it reaches `LONG_TICKS`, pulse `long[i]` and go to `LONG`. An accepted release → `UP`, with no `long` pulse.
  - `LONG`: an accepted release → `UP`. Without auto-repeat, no further pulses while held.
- **Hold counter.** `$clog2(LONG_TICKS+1)` bits. Saturates and never wraps.
- **Independence.** Buttons are fully independent. Simultaneous events on several buttons produce simultaneous pulses.
- **Pulse exclusivity.** `press` and `release` never assert together for the same button.

## Timing
- Reset values: `level`=0, `press`=0, `release`=0, `long`=0, `tick`=0. All FSMs are in `UP`, and all counters and synchronisers are cleared.
- **Reset mid-operation** discards all state immediately.
  - A button held through reset deassertion is seen as a new press after the debounce time.
  - The prescaler restarts from 0.
- **Input to `s[i]`:** 2–3 `clk` cycles.
- **Acceptance latency:** from `s[i]` changing to the `level` edge is between `DEB_TICKS-1` and `DEB_TICKS` tick periods, plus 1 cycle.
- **Output timing:** `level`, `press`, `release` and `long` are all registered. Pulses are exactly 1 `clk` cycle and are aligned with the `tick` cycle that caused them, appearing on the following edge.
- **Long-press timing:** `long` fires exactly `LONG_TICKS` ticks after the `press` pulse.

## Configuration
- **Macro `BTN_AUTOREPEAT_EN` defined:**
  - In `LONG`, a repeat counter counts ticks and pulses `press[i]` every `REPEAT_TICKS` ticks while the button is held.
  - The first repeat comes `REPEAT_TICKS` ticks after `long`.
  - The repeat counter clears on release and on reset.
- **Macro not defined:** no repeat logic is built. `LONG` is silent until release, and `REPEAT_TICKS` is ignored.

## Test plan
Bench parameters for all scenarios: `CLK_HZ`=1000, `TICK_HZ`=100 (tick every 10 cycles), `DEB_TICKS`=3, `LONG_TICKS`=10, `REPEAT_TICKS`=4, `NBTN`=2.
- **Reset:** hold `rst`=0 with `btn_n`=2'b00 (both pressed), then release reset.
  - All outputs stay 0 during reset.
  - `tick` first pulses at cycle 9 after release.
  - `level` becomes 2'b11 with `press`=2'b11 pulsed 1 cycle within 31 cycles.
- **Bounce rejection:** toggle `btn_n[0]` every 7 cycles for 100 cycles, then hold it at 1.
  - `level[0]` stays 0.
  - No `press` or `release` pulse.
- **Clean press/release:** drive `btn_n[0]`=0 for 60 cycles, then 1.
  - Exactly one `press[0]` pulse, 20–33 cycles after the press.
  - Exactly one `release[0]` pulse after the release.
  - No `long`.
- **Long press:** hold `btn_n[1]`=0 for 200 cycles.
  - `long[1]` pulses once, exactly 100 cycles after `press[1]`.
  - Without `BTN_AUTOREPEAT_EN`, there is no further `press[1]`.
- **Auto-repeat** (with `BTN_AUTOREPEAT_EN`), same stimulus as the long-press scenario:
  - `press[1]` pulses at `long`+40 and `long`+80 cycles.
  - Pulses stop after release.
- **Reset mid-hold:** pulse `rst` low for 3 cycles while in `LONG`.
  - Outputs clear immediately.
  - A new `press` appears after debounce.
  - `long` reappears 100 cycles later.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, tick-based debounce, press/release/long pulses.
// Define BTN_AUTOREPEAT_EN to add periodic press pulses while a long press is held.
// The release pulse output is named rel because "release" is a reserved word.
module btn_debounce #(
  parameter int NBTN         = 4,
  parameter int CLK_HZ       = 10_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int DEB_TICKS    = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBTN-1:0]   btn_n,
  output logic [NBTN-1:0]   level,
  output logic [NBTN-1:0]   press,
  output logic [NBTN-1:0]   rel,
  output logic [NBTN-1:0]   long,
  output logic              tick,
  output logic [2*NBTN-1:0] dbg_state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DEB_TICKS + 1);
  localparam int HW  = $clog2(LONG_TICKS + 1);

  if (DIV < 2 || DEB_TICKS < 1 || LONG_TICKS <= DEB_TICKS || REPEAT_TICKS < 1) begin : g_bad_params
    $error("btn_debounce: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2
  } btn_state_t;

  // Prescaler: tick is the terminal-count cycle of a free-running counter.
  logic [PW-1:0] pre_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (pre_q == PW'(DIV - 1)) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign tick = (pre_q == PW'(DIV - 1));

  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= ~btn_n;
      s_q     <= sync1_q;
    end
  end

  // Debounce: count ticks while the synced input disagrees with the accepted level.
  logic [DW-1:0]   deb_q [NBTN];
  logic [DW-1:0]   deb_d [NBTN];
  logic [NBTN-1:0] acc_press;
  logic [NBTN-1:0] acc_rel;

  always_comb begin
    acc_press = '0;
    acc_rel   = '0;
    for (int i = 0; i < NBTN; i++) begin
      deb_d[i] = deb_q[i];
      if (s_q[i] == level[i]) begin
        deb_d[i] = '0;
      end else if (tick) begin
        if (deb_q[i] == DW'(DEB_TICKS - 1)) begin
          deb_d[i]     = '0;
          acc_press[i] = ~level[i];
          acc_rel[i]   = level[i];
        end else begin
          deb_d[i] = deb_q[i] + DW'(1);
        end
      end
    end
  end

  btn_state_t      state_q [NBTN];
  btn_state_t      state_d [NBTN];
  logic [HW-1:0]   hold_q  [NBTN];
  logic [HW-1:0]   hold_d  [NBTN];
  logic [NBTN-1:0] long_d;
  logic [NBTN-1:0] press_d;
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  logic [RW-1:0]   rep_q [NBTN];
  logic [RW-1:0]   rep_d [NBTN];
`endif

  always_comb begin
    long_d  = '0;
    press_d = acc_press;
    for (int i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
`ifdef BTN_AUTOREPEAT_EN
      rep_d[i]   = rep_q[i];
`endif
      case (state_q[i])
        ST_UP: begin
          if (acc_press[i]) begin
            state_d[i] = ST_DOWN;
            hold_d[i]  = '0;
          end
        end
        ST_DOWN: begin
          if (acc_rel[i]) begin
            state_d[i] = ST_UP;
          end else if (tick) begin
            if (hold_q[i] == HW'(LONG_TICKS - 1)) begin
              hold_d[i]  = HW'(LONG_TICKS);
              long_d[i]  = 1'b1;
              state_d[i] = ST_LONG;
            end else begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
          end
        end
        ST_LONG: begin
          // Hold counter stays saturated here; release always wins over a repeat.
          if (acc_rel[i]) begin
            state_d[i] = ST_UP;
`ifdef BTN_AUTOREPEAT_EN
            rep_d[i]   = '0;
          end else if (tick) begin
            if (rep_q[i] == RW'(REPEAT_TICKS - 1)) begin
              rep_d[i]   = '0;
              press_d[i] = 1'b1;
            end else begin
              rep_d[i] = rep_q[i] + RW'(1);
            end
`endif
          end
        end
        default: state_d[i] = ST_UP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= ST_UP;
        hold_q[i]  <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
`ifdef BTN_AUTOREPEAT_EN
        rep_q[i]   <= rep_d[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      press <= '0;
      rel   <= '0;
      long  <= '0;
      for (int i = 0; i < NBTN; i++) begin
        deb_q[i] <= '0;
      end
    end else begin
      level <= level ^ (acc_press | acc_rel);
      press <= press_d;
      rel   <= acc_rel;
      long  <= long_d;
      for (int i = 0; i < NBTN; i++) begin
        deb_q[i] <= deb_d[i];
      end
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < NBTN; i++) begin
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: reset, bounce, clean press, long press,
// optional auto-repeat and reset during a hold, with a 10-cycle tick.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn_n = 2'b00;
  logic [1:0] level, press, rel, long;
  logic       tick;
  logic [3:0] dbg_state;

  btn_debounce #(
    .NBTN(2), .CLK_HZ(1000), .TICK_HZ(100),
    .DEB_TICKS(3), .LONG_TICKS(10), .REPEAT_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .level(level), .press(press),
    .rel(rel), .long(long), .tick(tick), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int press_cnt[2] = '{0, 0};
  int rel_cnt[2]   = '{0, 0};
  int long_cnt[2]  = '{0, 0};
  int press_cyc[2] = '{0, 0};
  int long_cyc[2]  = '{0, 0};
  int tick_cnt = 0;
  int excl_cnt = 0;
  int p1_q[$];

  always @(negedge clk) begin
    if (tick) tick_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (press[i]) begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (rel[i]) rel_cnt[i]++;
      if (long[i]) begin long_cnt[i]++; long_cyc[i] = cyc; end
      if (press[i] && rel[i]) excl_cnt++;
    end
    if (press[1]) p1_q.push_back(cyc);
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int r, t0, lat, pc, rc0, rc1, lc, qb, sz, tc;

  initial begin
    // Reset with both buttons pressed.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_level", {30'd0, level}, 0);
    check("rst_pulses", {26'd0, press, rel, long}, 0);
    check("rst_tick", {31'd0, tick}, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("tick_pre", {31'd0, tick}, 0);
    @(negedge clk);
    check("tick_first", {31'd0, tick}, 1);
    repeat (20) @(negedge clk);
    check("lvl_before_accept", {30'd0, level}, 0);
    @(negedge clk);
    check("lvl_accept", {30'd0, level}, 3);
    check("press_both", {30'd0, press}, 3);
    check("dbg_down", {28'd0, dbg_state}, 4'b0101);
    @(negedge clk);
    check("press_one_cycle", {30'd0, press}, 0);

    // Release both.
    rc0 = rel_cnt[0]; rc1 = rel_cnt[1];
    @(posedge clk); #1 btn_n = 2'b11;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("rel_level", {30'd0, level}, 0);
    check("rel0_count", rel_cnt[0] - rc0, 1);
    check("rel1_count", rel_cnt[1] - rc1, 1);
    check("no_long_short", long_cnt[0] + long_cnt[1], 0);

    // Tick period over 100 cycles.
    @(posedge clk); #1 tc = tick_cnt;
    repeat (100) @(posedge clk);
    #1 check("tick_rate", tick_cnt - tc, 10);

    // Bounce rejection.
    pc = press_cnt[0]; rc0 = rel_cnt[0];
    for (int k = 0; k < 14; k++) begin
      repeat (7) @(posedge clk);
      #1 btn_n[0] = ~btn_n[0];
    end
    btn_n[0] = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("bounce_level", {31'd0, level[0]}, 0);
    check("bounce_press", press_cnt[0] - pc, 0);
    check("bounce_rel", rel_cnt[0] - rc0, 0);

    // Clean press and release.
    pc = press_cnt[0]; rc0 = rel_cnt[0]; lc = long_cnt[0];
    @(posedge clk); #1 btn_n[0] = 1'b0; t0 = cyc;
    repeat (60) @(posedge clk);
    #1 btn_n[0] = 1'b1;
    check("clean_press_count", press_cnt[0] - pc, 1);
    lat = press_cyc[0] - t0;
    check("clean_press_latency_in_20_33", {31'd0, (lat >= 20 && lat <= 33)}, 1);
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("clean_rel_count", rel_cnt[0] - rc0, 1);
    check("clean_press_once", press_cnt[0] - pc, 1);
    check("clean_no_long", long_cnt[0] - lc, 0);
    check("clean_level", {30'd0, level}, 0);

    // Long press on button 1.
    lc = long_cnt[1]; rc1 = rel_cnt[1]; qb = p1_q.size();
    @(posedge clk); #1 btn_n[1] = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("long_state", {30'd0, dbg_state[3:2]}, 2);
    repeat (50) @(posedge clk);
    #1 btn_n[1] = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("long_count", long_cnt[1] - lc, 1);
    check("long_after_press", long_cyc[1] - ((p1_q.size() > qb) ? p1_q[qb] : 0), 100);
`ifdef BTN_AUTOREPEAT_EN
    check("repeat_count", p1_q.size() - qb, 3);
    check("repeat_first", ((p1_q.size() > qb + 1) ? p1_q[qb + 1] : 0) - long_cyc[1], 40);
    check("repeat_second", ((p1_q.size() > qb + 2) ? p1_q[qb + 2] : 0) - long_cyc[1], 80);
`else
    check("no_repeat", p1_q.size() - qb, 1);
`endif
    check("long_rel_count", rel_cnt[1] - rc1, 1);
    sz = p1_q.size();
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("quiet_after_release", p1_q.size() - sz, 0);

    // Reset while in LONG.
    @(posedge clk); #1 btn_n[1] = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("hold_state_long", {30'd0, dbg_state[3:2]}, 2);
    check("hold_level", {31'd0, level[1]}, 1);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("async_clear_level", {30'd0, level}, 0);
    check("async_clear_pulses", {26'd0, press, rel, long}, 0);
    check("async_clear_state", {28'd0, dbg_state}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; r = cyc;
    repeat (29) @(posedge clk);
    @(negedge clk);
    check("rehold_before", {30'd0, level}, 0);
    @(negedge clk);
    check("rehold_level", {30'd0, level}, 2'b10);
    check("rehold_press", {30'd0, press}, 2'b10);
    repeat (99) @(negedge clk);
    check("rehold_long_pre", {30'd0, long}, 0);
    @(negedge clk);
    check("rehold_long", {30'd0, long}, 2'b10);
    @(posedge clk); #1 btn_n[1] = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("final_level", {30'd0, level}, 0);
    check("press_rel_exclusive", excl_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
